// File: rtl/pxs_str_vga_split_chk.sv
// Splits a joined 23-bit VGA stream into registered sync/coord/active outputs and
// checks raster continuity. Optional ErrCnt port when PXS_SPLIT_ERRCNT_EN is defined.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_SEARCH  | not tracking; waiting for an active pixel at (0,0)
// S_ACQUIRE | tracking the first frame after (0,0); no full frame seen yet
// S_LOCKED  | at least one full error-free frame tracked
module pxs_str_vga_split_chk #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int FCNT_W   = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [22:0]       VGAStr_i,
    output logic              HSync,
    output logic              VSync,
    output logic [9:0]        XCoord,
    output logic [9:0]        YCoord,
    output logic              ActiveVideo,
    output logic              SOF,
    output logic              EOL,
    output logic              EOF,
    output logic              CoordErr,
    output logic              Locked,
`ifdef PXS_SPLIT_ERRCNT_EN
    output logic [7:0]        ErrCnt,
`endif
    output logic [FCNT_W-1:0] FrameCnt
);

    // Stream layout: {HS, VS, Active, XC[9:0], YC[9:0]}
    localparam int HS_BIT  = 22;
    localparam int VS_BIT  = 21;
    localparam int ACT_BIT = 20;
    localparam int XC_LSB  = 10;
    localparam int YC_LSB  = 0;

    localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0] Y_LAST = 10'(V_ACTIVE - 1);

    localparam logic [1:0] S_SEARCH  = 2'd0;
    localparam logic [1:0] S_ACQUIRE = 2'd1;
    localparam logic [1:0] S_LOCKED  = 2'd2;

    logic       in_hs;
    logic       in_vs;
    logic       in_act;
    logic [9:0] in_x;
    logic [9:0] in_y;

    assign in_hs  = VGAStr_i[HS_BIT];
    assign in_vs  = VGAStr_i[VS_BIT];
    assign in_act = VGAStr_i[ACT_BIT];
    assign in_x   = VGAStr_i[XC_LSB +: 10];
    assign in_y   = VGAStr_i[YC_LSB +: 10];

    logic              hs_q, hs_d;
    logic              vs_q, vs_d;
    logic [9:0]        x_q, x_d;
    logic [9:0]        y_q, y_d;
    logic              act_q, act_d;
    logic              sof_q, sof_d;
    logic              eol_q, eol_d;
    logic              eof_q, eof_d;
    logic              err_q, err_d;
    logic              locked_q, locked_d;
    logic [1:0]        state_q, state_d;
    logic [9:0]        ex_q, ex_d;
    logic [9:0]        ey_q, ey_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic [7:0]        errcnt_q, errcnt_d;

    logic [9:0] nx_x;
    logic [9:0] nx_y;
    logic       pos_match;

    // Position following the current input pixel in raster order
    always_comb begin
        nx_x = 10'd0;
        nx_y = 10'd0;
        if (in_x != X_LAST) begin
            nx_x = in_x + 10'd1;
            nx_y = in_y;
        end else if (in_y != Y_LAST) begin
            nx_y = in_y + 10'd1;
        end
    end

    assign pos_match = (in_x == ex_q) && (in_y == ey_q);

    always_comb begin
        hs_d  = in_hs;
        vs_d  = in_vs;
        x_d   = in_x;
        y_d   = in_y;
        act_d = in_act;
        sof_d = in_act && (in_x == 10'd0) && (in_y == 10'd0);
        eol_d = in_act && (in_x == X_LAST);
        eof_d = eol_d && (in_y == Y_LAST);

        state_d = state_q;
        ex_d    = ex_q;
        ey_d    = ey_q;
        fcnt_d  = fcnt_q;
        err_d   = 1'b0;

        case (state_q)
            S_SEARCH: begin
                if (sof_d) begin
                    state_d = S_ACQUIRE;
                    ex_d    = nx_x;
                    ey_d    = nx_y;
                end
            end
            S_ACQUIRE, S_LOCKED: begin
                if (in_act) begin
                    if (pos_match) begin
                        ex_d = nx_x;
                        ey_d = nx_y;
                        if (eof_d) begin
                            state_d = S_LOCKED;
                            fcnt_d  = fcnt_q + FCNT_W'(1);
                        end
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (ex_q != 10'd0) begin
                    // Blanking is only legal between lines
                    err_d = 1'b1;
                end
                if (err_d) begin
                    state_d = S_SEARCH;
                end
            end
            default: state_d = S_SEARCH;
        endcase

        locked_d = (state_d == S_LOCKED);

        errcnt_d = errcnt_q;
        if (err_d && (errcnt_q != 8'hFF)) begin
            errcnt_d = errcnt_q + 8'd1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            hs_q     <= 1'b0;
            vs_q     <= 1'b0;
            x_q      <= 10'd0;
            y_q      <= 10'd0;
            act_q    <= 1'b0;
            sof_q    <= 1'b0;
            eol_q    <= 1'b0;
            eof_q    <= 1'b0;
            err_q    <= 1'b0;
            locked_q <= 1'b0;
            state_q  <= S_SEARCH;
            ex_q     <= 10'd0;
            ey_q     <= 10'd0;
            fcnt_q   <= '0;
            errcnt_q <= 8'd0;
        end else begin
            hs_q     <= hs_d;
            vs_q     <= vs_d;
            x_q      <= x_d;
            y_q      <= y_d;
            act_q    <= act_d;
            sof_q    <= sof_d;
            eol_q    <= eol_d;
            eof_q    <= eof_d;
            err_q    <= err_d;
            locked_q <= locked_d;
            state_q  <= state_d;
            ex_q     <= ex_d;
            ey_q     <= ey_d;
            fcnt_q   <= fcnt_d;
            errcnt_q <= errcnt_d;
        end
    end

    assign HSync       = hs_q;
    assign VSync       = vs_q;
    assign XCoord      = x_q;
    assign YCoord      = y_q;
    assign ActiveVideo = act_q;
    assign SOF         = sof_q;
    assign EOL         = eol_q;
    assign EOF         = eof_q;
    assign CoordErr    = err_q;
    assign Locked      = locked_q;
    assign FrameCnt    = fcnt_q;

`ifdef PXS_SPLIT_ERRCNT_EN
    assign ErrCnt = errcnt_q;
`else
    logic unused_errcnt;
    assign unused_errcnt = ^errcnt_q;
`endif

endmodule

// File: tb/tb_pxs_str_vga_split_chk.sv
// Directed bench for pxs_str_vga_split_chk on a reduced 16x6 raster with a 2-bit
// frame counter; exercises ErrCnt saturation when PXS_SPLIT_ERRCNT_EN is defined.
module tb_pxs_str_vga_split_chk;

    localparam int H    = 16;
    localparam int V    = 6;
    localparam int HGAP = 4;
    localparam int VGAP = 2;
    localparam int FW   = 2;

    localparam int K_CLEAN = 0;
    localparam int K_SKIP  = 1;
    localparam int K_GAP   = 2;
    localparam int K_JUMP  = 3;

    logic          Clk = 1'b0;
    logic          Reset;
    logic [22:0]   VGAStr_i;
    logic          HSync, VSync, ActiveVideo, SOF, EOL, EOF, CoordErr, Locked;
    logic [9:0]    XCoord, YCoord;
    logic [FW-1:0] FrameCnt;
`ifdef PXS_SPLIT_ERRCNT_EN
    logic [7:0]    ErrCnt;
`endif

    pxs_str_vga_split_chk #(.H_ACTIVE(H), .V_ACTIVE(V), .FCNT_W(FW)) dut (
        .Clk(Clk), .Reset(Reset), .VGAStr_i(VGAStr_i),
        .HSync(HSync), .VSync(VSync), .XCoord(XCoord), .YCoord(YCoord),
        .ActiveVideo(ActiveVideo), .SOF(SOF), .EOL(EOL), .EOF(EOF),
        .CoordErr(CoordErr), .Locked(Locked),
`ifdef PXS_SPLIT_ERRCNT_EN
        .ErrCnt(ErrCnt),
`endif
        .FrameCnt(FrameCnt)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic          hs, vs, act;
        logic [9:0]    x, y;
        logic          sof, eol, eof, err, lck;
        logic [FW-1:0] fc;
        logic [7:0]    ec;
    } exp_t;

    exp_t          sb[$];
    int            n_vec = 0;
    int            n_err = 0;
    int            sof_seen = 0, eol_seen = 0, eof_seen = 0;
    bit            trk = 0, lck = 0;
    logic [FW-1:0] fc = '0;
    logic [7:0]    ec = 8'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // inj marks the cycle the stimulus deliberately breaks; the frame-level model
    // tracks acquisition at SOF, lock/count at EOF, and loss of lock on inj.
    task automatic drive(input logic hs, input logic vs, input logic act,
                         input logic [9:0] x, input logic [9:0] y, input logic inj);
        exp_t e;
        logic sof, eol, eof;
        sof = act && (x == 10'd0) && (y == 10'd0);
        eol = act && (x == 10'(H - 1));
        eof = eol && (y == 10'(V - 1));
        if (inj) begin
            trk = 0;
            lck = 0;
            if (ec != 8'd255) ec = ec + 8'd1;
        end else begin
            if (trk && eof) begin
                lck = 1;
                fc  = fc + 1'b1;
            end
            if (!trk && sof) trk = 1;
        end
        e = '{hs, vs, act, x, y, sof, eol, eof, inj, lck, fc, ec};
        sb.push_back(e);
        VGAStr_i = {hs, vs, act, x, y};
        @(posedge Clk);
        #1;
        e = sb.pop_front();
        chk("hsync", HSync, e.hs);
        chk("vsync", VSync, e.vs);
        chk("active", ActiveVideo, e.act);
        chk("xcoord", XCoord, e.x);
        chk("ycoord", YCoord, e.y);
        chk("sof", SOF, e.sof);
        chk("eol", EOL, e.eol);
        chk("eof", EOF, e.eof);
        chk("coorderr", CoordErr, e.err);
        chk("locked", Locked, e.lck);
        chk("framecnt", FrameCnt, e.fc);
`ifdef PXS_SPLIT_ERRCNT_EN
        chk("errcnt", ErrCnt, e.ec);
`endif
        if (SOF === 1'b1) sof_seen++;
        if (EOL === 1'b1) eol_seen++;
        if (EOF === 1'b1) eof_seen++;
    endtask

    task automatic send_lines(input int kind, input int bl, input int bx,
                              input int l0, input int l1);
        logic act, hs, vs;
        for (int ln = l0; ln <= l1; ln++) begin
            for (int x = 0; x < H + HGAP; x++) begin
                act = (ln < V) && (x < H);
                hs  = (x >= H + 1) && (x < H + 3);
                vs  = (ln >= V);
                if (kind == K_SKIP && ln == bl && x == bx) continue;
                if (kind == K_GAP && ln == bl && x == bx)
                    drive(1'b0, vs, 1'b0, 10'(x), 10'(ln), 1'b1);
                if (kind == K_JUMP && ln == bl && x == bx)
                    drive(hs, vs, 1'b1, 10'd0, 10'd0, 1'b1);
                else
                    drive(hs, vs, act, 10'(x), 10'(ln),
                          kind == K_SKIP && ln == bl && x == bx + 1);
            end
        end
    endtask

    task automatic send_frame(input int kind, input int bl, input int bx);
        send_lines(kind, bl, bx, 0, V + VGAP - 1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_hsync"}, HSync, 0);
        chk({tag, "_vsync"}, VSync, 0);
        chk({tag, "_xy"}, {XCoord, YCoord}, 0);
        chk({tag, "_active"}, ActiveVideo, 0);
        chk({tag, "_markers"}, {SOF, EOL, EOF}, 0);
        chk({tag, "_coorderr"}, CoordErr, 0);
        chk({tag, "_locked"}, Locked, 0);
        chk({tag, "_framecnt"}, FrameCnt, 0);
`ifdef PXS_SPLIT_ERRCNT_EN
        chk({tag, "_errcnt"}, ErrCnt, 0);
`endif
    endtask

    initial begin
        Reset    = 1'b1;
        VGAStr_i = 23'h7F_FFFF;
        repeat (2) @(posedge Clk);
        #1;
        chk_reset_outputs("por");
        Reset = 1'b0;

        // Five clean frames: FrameCnt 1,2,3 then wraps to 0,1
        for (int f = 0; f < 3; f++) send_frame(K_CLEAN, 0, 0);
        chk("sof_count", sof_seen, 3);
        chk("eol_count", eol_seen, 3 * V);
        chk("eof_count", eof_seen, 3);
        for (int f = 0; f < 2; f++) send_frame(K_CLEAN, 0, 0);

        send_frame(K_SKIP, 3, 9);
        send_frame(K_CLEAN, 0, 0);
        send_frame(K_GAP, 5, 7);
        send_frame(K_CLEAN, 0, 0);
        send_frame(K_JUMP, 2, 5);
        send_frame(K_CLEAN, 0, 0);

        // Reset mid-frame, then resume the same frame without a fresh (0,0)
        send_lines(K_CLEAN, 0, 0, 0, 1);
        Reset = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        trk = 0;
        lck = 0;
        fc  = '0;
        ec  = 8'd0;
        sb.delete();
        repeat (2) @(posedge Clk);
        #1;
        chk_reset_outputs("rsthold");
        Reset = 1'b0;
        send_lines(K_CLEAN, 0, 0, 2, V + VGAP - 1);
        send_frame(K_CLEAN, 0, 0);
        chk("final_framecnt", FrameCnt, 1);

`ifdef PXS_SPLIT_ERRCNT_EN
        for (int i = 0; i < 300; i++) begin
            drive(1'b0, 1'b0, 1'b1, 10'd0, 10'd0, 1'b0);
            drive(1'b0, 1'b0, 1'b0, 10'd1, 10'd0, 1'b1);
        end
        chk("errcnt_sat", ErrCnt, 255);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pxs_str_vga_split_chk.md
Name: pxs_str_vga_split_chk

Overview:
- Receive side of the VGA pixel stream: splits the 23-bit VGA stream (S, C, A fields) back into separate sync, coordinate and active signals, registered.
- Also checks stream integrity: tracks the expected raster position and flags coordinate discontinuities.
- Generates frame/line markers (SOF/EOL/EOF) and a frame counter.
- Sits at the input of any pixel-processing block that consumes a joined VGA stream.

Parameters:
- H_ACTIVE, 640, active pixels per line
- V_ACTIVE, 480, active lines per frame
- FCNT_W, 16, frame counter width

Ports:
- Clk  in  1  pixel clock; all logic rising-edge
- Reset  in  1  asynchronous, active-high reset
- VGAStr_i  in  23  input stream; field positions per Pxs.vh macros HS, VS, Active, XC, YC
- HSync  out  1  registered HS field
- VSync  out  1  registered VS field
- XCoord  out  10  registered XC field
- YCoord  out  10  registered YC field
- ActiveVideo  out  1  registered Active field
- SOF  out  1  pulse with the pixel at (0,0) when active
- EOL  out  1  pulse with the pixel at X=H_ACTIVE-1 when active
- EOF  out  1  pulse with the pixel at (H_ACTIVE-1, V_ACTIVE-1) when active
- CoordErr  out  1  one-cycle pulse on detected discontinuity
- Locked  out  1  a full error-free frame has been tracked
- FrameCnt  out  FCNT_W  count of EOFs seen while tracking; wraps

Behaviour:
- Reset is asynchronous and active-high; one clock Clk.
- All outputs reset to 0; the FSM resets to SEARCH.
- Latency: every output is registered exactly 1 cycle after the VGAStr_i sample it describes. Markers and CoordErr align with the registered pixel.
- Split is pure field extraction; no modification of values.
- Input pixel A is active when its Active bit is 1; its coordinates are (x,y).
- FSM states: SEARCH, ACQUIRE, LOCKED.
  - SEARCH: ignores checks. On an active pixel at (0,0) -> ACQUIRE; expected position set to (1,0).
  - ACQUIRE/LOCKED: each cycle, compare against the expected position (ex,ey).
    - Active with (x,y)==(ex,ey): advance expected position.
      - If x<H_ACTIVE-1: next expected is (x+1,y) on the very next cycle; active pixels in a line are contiguous.
      - If x==H_ACTIVE-1 and y<V_ACTIVE-1: next expected is (0,y+1); any number of inactive cycles allowed before it.
      - If x==H_ACTIVE-1 and y==V_ACTIVE-1: next expected is (0,0); inactive gap allowed.
    - Error cases:
      - Active pixel with (x,y)!=(ex,ey).
      - Inactive cycle while mid-line (expected X != 0).
      - Either error: CoordErr=1 for one cycle, Locked->0, go to SEARCH.
      - An error pixel at (0,0) is not re-acquired in the same cycle; re-acquisition starts from the next (0,0).
    - EOF in ACQUIRE: -> LOCKED, Locked=1 on the same registered cycle as EOF, FrameCnt+1.
    - EOF in LOCKED: FrameCnt+1, wrapping from all-ones to 0.
- FrameCnt holds its value across loss of lock; it clears only on Reset.
- SOF/EOL/EOF are decoded from coordinates and Active alone, in every state, including SEARCH.
- HS/VS are passed through and not checked.
- Reset mid-frame: outputs clear immediately; tracking restarts in SEARCH.

Optional Feature:
- Macro: PXS_SPLIT_ERRCNT_EN.
- Defined: extra output port ErrCnt (out, 8 bits), reset 0.
  - Increments on each CoordErr pulse and saturates at 255.
  - Cleared only by Reset.
- Undefined: no ErrCnt port or logic; the rest of the behaviour is identical.

Test Plan:
- Reset: assert Reset mid-stream -> all outputs 0 immediately; FSM in SEARCH; FrameCnt=0.
- Clean stream: 3 frames of 640x480, 160-cycle line gaps, 45-line vertical gap -> outputs equal inputs delayed 1 cycle.
  - Exactly 3 SOF, 1440 EOL, 3 EOF.
  - Locked=1 from the first EOF onward.
  - FrameCnt=3; CoordErr never asserted.
- Skipped pixel: in frame 2, line 10, jump from X=99 to X=101 -> CoordErr pulse on the X=101 output cycle; Locked=0.
  - Relocks after the next full frame; FrameCnt does not increment for the broken frame.
- Active gap mid-line: Active=0 for one cycle at X=300 of line 5 -> CoordErr=1; Locked=0; FSM returns to SEARCH.
- Wrap: FCNT_W=2, 5 clean frames -> FrameCnt sequence 1,2,3,0,1.
- With PXS_SPLIT_ERRCNT_EN: inject 300 errors -> ErrCnt saturates at 255.
  - Without the macro: the design compiles with no ErrCnt port.
